snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Game-state controller for the snake display. It owns the snake's segment positions, the food cell and the game state, and advances the game once every `FRAMES_PER_STEP` vertical blanks. It answers per-pixel "what is here" queries from the VGA timing block, so the display never reads state while that state is changing.

## Interface

**Parameters**
- `GRID_W`, 40: playfield width in cells (640 px / 16).
- `GRID_H`, 30: playfield height in cells (480 px / 16).
- `CELL_SHIFT`, 4: log2 of the cell size in pixels.
- `MAX_LEN`, 16: number of segment slots.
- `INIT_LEN`, 3: snake length after INIT.
- `FRAMES_PER_STEP`, 8: number of frames per game step.

**Ports**
- `iCLK` in 1: pixel clock.
- `iRST_N` in 1: reset. One clock; reset is asynchronous and active-low.
- `iFrame_Start` in 1: one-cycle pulse at the start of vertical blank.
- `iDir` in 2: requested direction. 00 right, 01 down, 10 left, 11 up.
- `iDir_Valid` in 1: qualifies `iDir`.
- `iPause` in 1: level signal. Freezes the step counter.
- `iRestart` in 1: one-cycle pulse. Honoured only in OVER.
- `iCoord_X` in 10: active-area pixel X being rendered.
- `iCoord_Y` in 10: active-area pixel Y being rendered.
- `oPix_Head` out 1: queried cell holds the head.
- `oPix_Body` out 1: queried cell holds a non-head segment.
- `oPix_Food` out 1: queried cell holds the food.
- `oLen` out 5: current snake length.
- `oGame_Over` out 1: high while in OVER.

## Operation

**State storage**
- Segment arrays `seg_x[MAX_LEN]` (6 b) and `seg_y[MAX_LEN]` (5 b). Slot 0 is the head.
- `len` (5 b), `dir` and `pend_dir` (2 b each).
- Food at `food_x` (6 b), `food_y` (5 b).
- Frame counter (3 b minimum).
- 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1. Advances every cycle, including during reset release.

**FSM states:** INIT, RUN, STEP, COMMIT, FOOD, OVER.

- **INIT** (1 cycle), then RUN:
  - head (20,15); segment k at (20-k, 15) for k < INIT_LEN.
  - `len` = INIT_LEN; `dir` = `pend_dir` = right.
  - food at (30,15); frame counter cleared.
- **RUN:**
  - `iDir_Valid` loads `pend_dir` unless `iDir` is the exact reverse of `dir`. A reverse request is ignored.
  - On `iFrame_Start` with `iPause` low, the frame counter increments.
  - When the counter reaches FRAMES_PER_STEP-1 and `iFrame_Start` arrives, the counter clears and the FSM goes to STEP.
- **STEP** (1 cycle):
  - `dir` takes `pend_dir`; compute the next head `nx`/`ny` from it.
  - Wrap-around: X = GRID_W-1 moving right becomes 0; X = 0 moving left becomes GRID_W-1. Y wraps the same way with GRID_H.
  - `grow` = (`nx`,`ny`) equals the food cell.
  - Collision: (`nx`,`ny`) equals any segment k < `len`, excluding k = `len`-1 when `grow` = 0 (that tail cell vacates this step).
  - Collision goes to OVER. Otherwise go to COMMIT.
- **COMMIT** (1 cycle):
  - Shift `seg[k]` ← `seg[k-1]` for all k, then `seg[0]` ← (`nx`,`ny`).
  - If `grow`: `len` ← min(`len`+1, MAX_LEN), then go to FOOD. Else go to RUN.
  - At MAX_LEN, eating still relocates the food, but the length stays saturated.
- **FOOD:**
  - Each cycle, sample `lfsr[5:0]` as X and `lfsr[12:8]` as Y.
  - Accept when X < GRID_W, Y < GRID_H, and the cell does not match any segment k < `len`. On accept, load the food cell and go to RUN. On reject, retry next cycle.
- **OVER:**
  - State is frozen and `oGame_Over` = 1.
  - `iRestart` goes to INIT. Direction input is ignored.

**Pixel query**
- cell = (`iCoord_X` >> CELL_SHIFT, `iCoord_Y` >> CELL_SHIFT).
- `oPix_Head` = (cell == `seg[0]`).
- `oPix_Body` = any k in 1..`len`-1 matches.
- `oPix_Food` = (cell == food).
- Slots k ≥ `len` never match.

## Timing

- Reset values: all outputs 0, except `oLen` = 0 until INIT completes. INIT executes on the first clock after reset release, so `oLen` = INIT_LEN from the second clock.
- Pixel outputs are registered: 1-cycle latency from `iCoord_X`/`iCoord_Y`.
- Latency from `iFrame_Start` to updated segments:
  - 2 cycles (STEP, COMMIT) when not eating.
  - With growth, the food is stable after 3 cycles plus any FOOD retries.
- All updates land inside vertical blank.
- Simultaneous events:
  - `iDir_Valid` in the same cycle as the stepping `iFrame_Start` is captured in `pend_dir` and applied in that STEP.
  - `iFrame_Start` arriving while the FSM is in STEP, COMMIT or FOOD is not counted.
- `iPause` high holds the counter but still accepts direction changes.
- Reset asserted mid-step: immediate return to reset values, then INIT on release.

## Test plan

- Reset, 8 frame pulses → `oLen` = 3. Query pixel (336,240) → `oPix_Head` = 1 one cycle later; head now at (21,15).
- Head at (39,15) moving right, one step → head at (0,15). Moving up from (5,0) → head at (5,29).
- Dir = right, assert `iDir` = left → ignored. Assert `iDir` = up → after the next step, head Y decreases by 1.
- Place the food one cell ahead of the head, step → `oLen` increments by 1. New food lies inside the grid and off the snake; FOOD exits within a bounded number of retries.
- Steer the head into its own body (length ≥ 5) → `oGame_Over` = 1 and segments unchanged. `iRestart` → `oLen` = 3 and head at (20,15).
- Hold `iPause` for 20 frames → no movement. Release → step after 8 further frame pulses.

Source files
------------

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : snake_game_ctrl
// Snake game state, stepping FSM and registered per-pixel cell query.
// Revision : 1.0
// =============================================================================
module snake_game_ctrl #(
    parameter int GRID_W          = 40,
    parameter int GRID_H          = 30,
    parameter int CELL_SHIFT      = 4,
    parameter int MAX_LEN         = 16,
    parameter int INIT_LEN        = 3,
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iFrame_Start,
    input  logic [1:0] iDir,
    input  logic       iDir_Valid,
    input  logic       iPause,
    input  logic       iRestart,
    input  logic [9:0] iCoord_X,
    input  logic [9:0] iCoord_Y,
    output logic       oPix_Head,
    output logic       oPix_Body,
    output logic       oPix_Food,
    output logic [4:0] oLen,
    output logic       oGame_Over
);
    localparam int         FCW       = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_COMMIT = 3'd3,
        S_FOOD   = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [5:0]     seg_x [MAX_LEN];
    logic [4:0]     seg_y [MAX_LEN];
    logic [4:0]     len;
    logic [1:0]     dir, pend_dir;
    logic [5:0]     food_x;
    logic [4:0]     food_y;
    logic [FCW-1:0] frame_cnt;
    logic [15:0]    lfsr;
    logic [5:0]     nx_q;
    logic [4:0]     ny_q;
    logic           grow_q;

    logic [5:0]         nx;
    logic [4:0]         ny;
    logic               grow, collide, step_go, food_ok;
    logic [5:0]         rnd_x;
    logic [4:0]         rnd_y;
    logic [9:0]         cell_x, cell_y;
    logic [MAX_LEN-1:0] live, tail, hit_next, hit_rnd, hit_pix;

    assign rnd_x  = lfsr[5:0];
    assign rnd_y  = lfsr[12:8];
    assign cell_x = iCoord_X >> CELL_SHIFT;
    assign cell_y = iCoord_Y >> CELL_SHIFT;

    genvar g;
    generate
        for (g = 0; g < MAX_LEN; g++) begin : g_slot
            assign live[g]     = (5'(g) < len);
            assign tail[g]     = (5'(g) == len - 5'd1);
            assign hit_next[g] = (seg_x[g] == nx) && (seg_y[g] == ny);
            assign hit_rnd[g]  = (seg_x[g] == rnd_x) && (seg_y[g] == rnd_y);
            assign hit_pix[g]  = (10'(seg_x[g]) == cell_x) && (10'(seg_y[g]) == cell_y);
        end
    endgenerate

    // Next head from the pending direction, with toroidal wrap.
    always_comb begin
        nx = seg_x[0];
        ny = seg_y[0];
        case (pend_dir)
            DIR_RIGHT: nx = (seg_x[0] == 6'(GRID_W - 1)) ? 6'd0 : seg_x[0] + 6'd1;
            DIR_DOWN:  ny = (seg_y[0] == 5'(GRID_H - 1)) ? 5'd0 : seg_y[0] + 5'd1;
            DIR_LEFT:  nx = (seg_x[0] == 6'd0) ? 6'(GRID_W - 1) : seg_x[0] - 6'd1;
            DIR_UP:    ny = (seg_y[0] == 5'd0) ? 5'(GRID_H - 1) : seg_y[0] - 5'd1;
            default:   nx = seg_x[0];
        endcase
    end

    // The tail cell is free this step unless the snake grows.
    assign grow    = (nx == food_x) && (ny == food_y);
    assign collide = |(hit_next & live & ~(tail & {MAX_LEN{~grow}}));
    assign food_ok = (rnd_x < 6'(GRID_W)) && (rnd_y < 5'(GRID_H)) && !(|(hit_rnd & live));
    assign step_go = iFrame_Start && !iPause && (frame_cnt == FCW'(FRAMES_PER_STEP - 1));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= S_INIT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = S_RUN;
            S_RUN:    if (step_go) state_nxt = S_STEP;
            S_STEP:   state_nxt = collide ? S_OVER : S_COMMIT;
            S_COMMIT: state_nxt = grow_q ? S_FOOD : S_RUN;
            S_FOOD:   if (food_ok) state_nxt = S_RUN;
            S_OVER:   if (iRestart) state_nxt = S_INIT;
            default:  state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) lfsr <= 16'hACE1;
        else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x[k] <= '0;
                seg_y[k] <= '0;
            end
            len       <= '0;
            dir       <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            food_x    <= '0;
            food_y    <= '0;
            frame_cnt <= '0;
            nx_q      <= '0;
            ny_q      <= '0;
            grow_q    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    for (int k = 0; k < MAX_LEN; k++) begin
                        if (k < INIT_LEN) begin
                            seg_x[k] <= 6'(GRID_W / 2 - k);
                            seg_y[k] <= 5'(GRID_H / 2);
                        end else begin
                            seg_x[k] <= '0;
                            seg_y[k] <= '0;
                        end
                    end
                    len       <= 5'(INIT_LEN);
                    dir       <= DIR_RIGHT;
                    pend_dir  <= DIR_RIGHT;
                    food_x    <= 6'((GRID_W * 3) / 4);
                    food_y    <= 5'(GRID_H / 2);
                    frame_cnt <= '0;
                end
                S_RUN: begin
                    if (iDir_Valid && (iDir != (dir ^ 2'b10)))
                        pend_dir <= iDir;
                    if (iFrame_Start && !iPause)
                        frame_cnt <= step_go ? '0 : frame_cnt + 1'b1;
                end
                S_STEP: begin
                    dir    <= pend_dir;
                    nx_q   <= nx;
                    ny_q   <= ny;
                    grow_q <= grow;
                end
                S_COMMIT: begin
                    for (int k = MAX_LEN - 1; k > 0; k--) begin
                        seg_x[k] <= seg_x[k-1];
                        seg_y[k] <= seg_y[k-1];
                    end
                    seg_x[0] <= nx_q;
                    seg_y[0] <= ny_q;
                    if (grow_q && (len < 5'(MAX_LEN)))
                        len <= len + 5'd1;
                end
                S_FOOD: begin
                    if (food_ok) begin
                        food_x <= rnd_x;
                        food_y <= rnd_y;
                    end
                end
                default: ;
            endcase
        end
    end

    // Food is hidden until INIT has placed it (len is zero only before then).
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oPix_Head <= 1'b0;
            oPix_Body <= 1'b0;
            oPix_Food <= 1'b0;
        end else begin
            oPix_Head <= hit_pix[0] & live[0];
            oPix_Body <= |(hit_pix[MAX_LEN-1:1] & live[MAX_LEN-1:1]);
            oPix_Food <= (len != 5'd0) && (10'(food_x) == cell_x) && (10'(food_y) == cell_y);
        end
    end

    assign oLen       = len;
    assign oGame_Over = (state == S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_snake_game_ctrl
// Directed self-checking bench for snake_game_ctrl.
// Revision : 1.0
// =============================================================================
module tb_snake_game_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start, dir_valid, pause, restart;
    logic [1:0] dir_in;
    logic [9:0] coord_x, coord_y;
    logic       pix_head, pix_body, pix_food, game_over;
    logic [4:0] len_out;

    int n_cmp = 0;
    int n_err = 0;
    int hx, hy, hdir, exp_len, fx, fy;

    snake_game_ctrl dut (
        .iCLK         (clk),
        .iRST_N       (rst_n),
        .iFrame_Start (frame_start),
        .iDir         (dir_in),
        .iDir_Valid   (dir_valid),
        .iPause       (pause),
        .iRestart     (restart),
        .iCoord_X     (coord_x),
        .iCoord_Y     (coord_y),
        .oPix_Head    (pix_head),
        .oPix_Body    (pix_body),
        .oPix_Food    (pix_food),
        .oLen         (len_out),
        .oGame_Over   (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic query(input int x, input int y, output logic h, output logic b, output logic f);
        @(negedge clk);
        coord_x = 10'(x * 16 + 5);
        coord_y = 10'(y * 16 + 11);
        @(negedge clk);
        h = pix_head;
        b = pix_body;
        f = pix_food;
    endtask

    task automatic frame(input bit with_dir, input int d);
        @(negedge clk);
        frame_start = 1'b1;
        if (with_dir) begin
            dir_in    = 2'(d);
            dir_valid = 1'b1;
        end
        @(negedge clk);
        frame_start = 1'b0;
        dir_valid   = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic dir_pulse(input int d);
        @(negedge clk);
        dir_in    = 2'(d);
        dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    task automatic scan_food();
        logic h, b, f;
        int cnt = 0;
        int on_snake = 0;
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++) begin
                query(x, y, h, b, f);
                if (f === 1'b1) begin
                    cnt++;
                    fx = x;
                    fy = y;
                    if (h === 1'b1 || b === 1'b1) on_snake++;
                end
            end
        check("food_count_in_grid", cnt, 1);
        check("food_off_snake", on_snake, 0);
    endtask

    // Moves the model head one cell, handles eating, and checks the DUT agrees.
    task automatic advance(input string tag);
        logic h, b, f;
        case (hdir)
            0: hx = (hx == 39) ? 0 : hx + 1;
            1: hy = (hy == 29) ? 0 : hy + 1;
            2: hx = (hx == 0) ? 39 : hx - 1;
            default: hy = (hy == 0) ? 29 : hy - 1;
        endcase
        if (hx == fx && hy == fy) begin
            if (exp_len < 16) exp_len++;
            repeat (60) @(negedge clk);
            scan_food();
        end
        query(hx, hy, h, b, f);
        check({tag, "_head"}, h, 1);
        check({tag, "_len"}, len_out, exp_len);
        check({tag, "_over"}, game_over, 0);
    endtask

    // mode 0: no request, 1: request before the frames, 2: request with the stepping frame
    task automatic step(input string tag, input int d, input int mode, input bit exp_over);
        logic h, b, f;
        int ox = hx;
        int oy = hy;
        if (mode == 1) dir_pulse(d);
        repeat (7) frame(0, 0);
        frame(mode == 2, d);
        if (mode != 0 && ((d ^ 2) != hdir)) hdir = d;
        if (exp_over) begin
            check({tag, "_over"}, game_over, 1);
            check({tag, "_len"}, len_out, exp_len);
            query(ox, oy, h, b, f);
            check({tag, "_head_frozen"}, h, 1);
        end else begin
            advance(tag);
        end
    endtask

    initial begin
        logic h, b, f;
        rst_n = 1'b0; frame_start = 1'b0; dir_valid = 1'b0; pause = 1'b0;
        restart = 1'b0; dir_in = 2'd0; coord_x = '0; coord_y = '0;
        repeat (3) @(negedge clk);
        check("rst_len", len_out, 0);
        check("rst_over", game_over, 0);
        check("rst_head", pix_head, 0);
        check("rst_body", pix_body, 0);
        check("rst_food", pix_food, 0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("init_len", len_out, 3);
        hx = 20; hy = 15; hdir = 0; exp_len = 3; fx = 30; fy = 15;

        query(20, 15, h, b, f); check("init_head", h, 1);
        query(19, 15, h, b, f); check("init_body1", b, 1);
        query(18, 15, h, b, f); check("init_body2", b, 1);
        query(17, 15, h, b, f); check("init_past_tail", b, 0);
        query(30, 15, h, b, f); check("init_food", f, 1);
        query(21, 15, h, b, f); check("init_not_head", h, 0);

        // Reverse request is ignored: still moves right.
        step("reverse_ignored", 2, 1, 0);
        query(20, 15, h, b, f); check("old_head_is_body", b, 1);

        // Pause holds the counter but direction changes are still taken.
        pause = 1'b1;
        dir_pulse(3);
        repeat (20) frame(0, 0);
        query(21, 15, h, b, f); check("pause_no_move", h, 1);
        pause = 1'b0;
        repeat (7) frame(0, 0);
        query(21, 15, h, b, f); check("unpause_7_no_move", h, 1);
        frame(0, 0);
        hdir = 3;
        advance("unpause_step_up");

        step("simul_right", 0, 2, 0);
        step("down", 1, 1, 0);
        step("right", 0, 1, 0);
        while (hx != 39) step("run_right", 0, 0, 0);
        check("grew_on_food", (exp_len >= 4) ? 1 : 0, 1);
        step("wrap_x", 0, 0, 0);
        check("wrap_x_pos", hx, 0);
        query(39, 15, h, b, f); check("wrap_x_prev_body", b, 1);

        step("turn_up", 3, 1, 0);
        while (hy != 0) step("run_up", 3, 0, 0);
        step("wrap_y", 3, 0, 0);
        check("wrap_y_pos", hy, 29);

        for (int i = 0; i < 300 && exp_len < 5; i++) begin
            int d;
            if (hx != fx) begin
                d = (fx > hx) ? 0 : 2;
                if ((d ^ 2) == hdir) d = 1;
            end else begin
                d = (fy > hy) ? 1 : 3;
                if ((d ^ 2) == hdir) d = 0;
            end
            step("nav", d, 1, 0);
        end
        check("len_at_least_5", (exp_len >= 5) ? 1 : 0, 1);

        // Straighten the body, then turn clockwise three times into it.
        repeat (6) step("straight", hdir, 0, 0);
        step("cw1", (hdir + 1) % 4, 1, 0);
        step("cw2", (hdir + 1) % 4, 1, 0);
        step("cw3_collide", (hdir + 1) % 4, 1, 1);
        repeat (8) frame(1, (hdir + 1) % 4);
        check("over_frozen_len", len_out, exp_len);
        check("over_still", game_over, 1);
        query(hx, hy, h, b, f); check("over_head_frozen", h, 1);

        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        @(negedge clk);
        check("restart_len", len_out, 3);
        check("restart_over", game_over, 0);
        query(20, 15, h, b, f); check("restart_head", h, 1);

        // Reset in the middle of a step.
        repeat (7) frame(0, 0);
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midstep_rst_len", len_out, 0);
        check("midstep_rst_head", pix_head, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_len", len_out, 3);
        query(20, 15, h, b, f); check("post_rst_head", h, 1);
        query(21, 15, h, b, f); check("post_rst_no_step", h, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
